// File: rtl/gigatron_video_capture.sv
// rtl/gigatron_video_capture.sv - Gigatron video byte capture into a 160x120 framebuffer
module gigatron_video_capture #(
    parameter int H_BACK = 12,
    parameter int H_PIX  = 160,
    parameter int V_BACK = 33,
    parameter int V_PIX  = 120,
    parameter int V_REP  = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_ready,
    input  logic [7:0]  i_out,
    output logic        o_fb_we,
    output logic [14:0] o_fb_addr,
    output logic [5:0]  o_fb_data,
    output logic        o_frame,
    output logic        o_locked
);

    typedef enum logic [1:0] {IDLE, VBACK, ACTIVE, VFRONT} state_t;

    localparam logic [8:0]  H_LO     = 9'(H_BACK);
    localparam logic [8:0]  H_HI     = 9'(H_BACK + H_PIX);
    localparam logic [7:0]  H_BACK_W = 8'(H_BACK);
    localparam logic [9:0]  V_START  = 10'(V_BACK);
    localparam logic [9:0]  V_END    = 10'(V_BACK + V_PIX * V_REP);
    localparam logic [9:0]  V_REP_W  = 10'(V_REP);
    localparam logic [14:0] H_PIX_W  = 15'(H_PIX);

    state_t      state;
    // Only the sync bits of the previous tick matter for edge detection: {vsync, hsync}
    logic [1:0]  prev_sync;
    logic [7:0]  hcnt;
    logic [9:0]  vline;

    logic        hs_rise;
    logic        vs_rise;
    logic        vs_fall;
    logic [9:0]  vline_inc;
    logic [9:0]  vrel;
    logic [9:0]  row;
    logic [7:0]  col;
    logic        h_vis;
    logic        v_vis;
    logic        pix_we;
    logic [14:0] pix_addr;

    assign hs_rise   = ~prev_sync[0] & i_out[6];
    assign vs_rise   = ~prev_sync[1] & i_out[7];
    assign vs_fall   =  prev_sync[1] & ~i_out[7];
    assign vline_inc = (vline == 10'h3FF) ? vline : vline + 10'd1;

    // Position of the current tick relative to the visible window (pre-update counters)
    assign vrel     = vline - V_START;
    assign row      = vrel / V_REP_W;
    assign col      = hcnt - H_BACK_W;
    assign h_vis    = ({1'b0, hcnt} >= H_LO) && ({1'b0, hcnt} < H_HI);
    assign v_vis    = (vrel % V_REP_W) == 10'd0;
    assign pix_we   = (state == ACTIVE) && !hs_rise && h_vis && v_vis;
    assign pix_addr = 15'(row) * H_PIX_W + 15'(col);

    // Sync edge history and beam position counters, advancing only on ticks
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            prev_sync <= 2'b11;
            hcnt      <= 8'd0;
            vline     <= 10'd0;
        end else if (i_ready) begin
            prev_sync <= i_out[7:6];
            if (hs_rise)
                hcnt <= 8'd0;
            else if (hcnt != 8'hFF)
                hcnt <= hcnt + 8'd1;
            if (vs_rise)
                vline <= 10'd0;
            else if (hs_rise)
                vline <= vline_inc;
        end
    end

    // Frame state machine with registered write port, frame pulse and lock flag
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            o_fb_we   <= 1'b0;
            o_fb_addr <= 15'd0;
            o_fb_data <= 6'd0;
            o_frame   <= 1'b0;
            o_locked  <= 1'b0;
        end else begin
            o_fb_we <= 1'b0;
            o_frame <= 1'b0;
            if (i_ready) begin
                if (pix_we) begin
                    o_fb_we   <= 1'b1;
                    o_fb_addr <= pix_addr;
                    o_fb_data <= i_out[5:0];
                end
                if (vs_rise) begin
                    state <= VBACK;
                end else begin
                    case (state)
                        IDLE: ;
                        VBACK: begin
                            if (vs_fall) begin
                                state    <= IDLE;
                                o_locked <= 1'b0;
                            end else if (hs_rise && vline_inc == V_START) begin
                                state <= ACTIVE;
                            end
                        end
                        ACTIVE: begin
                            if (vs_fall) begin
                                state    <= IDLE;
                                o_locked <= 1'b0;
                            end else if (hs_rise && vline_inc == V_END) begin
                                state    <= VFRONT;
                                o_frame  <= 1'b1;
                                o_locked <= 1'b1;
                            end
                        end
                        VFRONT: ;
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_gigatron_video_capture.sv
// tb/tb_gigatron_video_capture.sv - self-checking bench for gigatron_video_capture
module tb_gigatron_video_capture;

    localparam int HB  = 4;
    localparam int HP  = 16;
    localparam int VB  = 5;
    localparam int VP  = 6;
    localparam int VR  = 4;
    localparam int LT  = 40;
    localparam int HSL = 6;
    localparam int NL  = 40;
    localparam int T0  = HSL + 1 + HB;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_ready;
    logic [7:0]  i_out;
    logic        o_fb_we;
    logic [14:0] o_fb_addr;
    logic [5:0]  o_fb_data;
    logic        o_frame;
    logic        o_locked;

    always #5 i_clock = ~i_clock;

    gigatron_video_capture #(
        .H_BACK(HB), .H_PIX(HP), .V_BACK(VB), .V_PIX(VP), .V_REP(VR)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_ready(i_ready), .i_out(i_out),
        .o_fb_we(o_fb_we), .o_fb_addr(o_fb_addr), .o_fb_data(o_fb_data),
        .o_frame(o_frame), .o_locked(o_locked)
    );

    int          checks = 0;
    int          failures = 0;
    logic [20:0] exp_q[$];
    logic [20:0] e_cmp;
    logic        drv_frame = 1'b0;
    logic        cap_frame = 1'b0;
    logic        running = 1'b0;
    logic        stall = 1'b0;
    int          wr_total = 0;
    int          frames_seen = 0;
    logic [5:0]  d_first;
    logic [5:0]  d_last;
    logic        lock_mid;
    int          frames_mid;
    int          base;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-clock comparison against the expected write queue and frame pulse
    always @(negedge i_clock) begin
        if (running && !i_reset) begin
            check("frame_pulse", int'(o_frame), int'(cap_frame));
            if (o_frame) frames_seen++;
            if (o_fb_we) begin
                wr_total++;
                if (o_fb_addr == 15'(0)) d_first = o_fb_data;
                if (o_fb_addr == 15'(VP * HP - 1)) d_last = o_fb_data;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr %0d data %0d expected no write", o_fb_addr, o_fb_data);
                end else begin
                    e_cmp = exp_q.pop_front();
                    check("wr_addr", int'(o_fb_addr), int'(e_cmp[20:6]));
                    check("wr_data", int'(o_fb_data), int'(e_cmp[5:0]));
                end
            end
        end
    end

    // One CPU tick; with stall enabled, i_ready is randomly low on some clocks
    task automatic do_tick(input logic [7:0] v, input logic frm, input logic wr,
                           input logic [14:0] a, input logic [5:0] d);
        logic rdy;
        do begin
            @(posedge i_clock);
            #1;
            cap_frame = drv_frame;
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            i_ready = rdy;
            i_out = v;
            drv_frame = rdy & frm;
            if (rdy && wr) exp_q.push_back({a, d});
        end while (!rdy);
    endtask

    // Drives nl lines of a frame; vsync low on lines 0..1, rising at t=0 of line 2
    // (or together with hsync when simul). rl>=0 resets the DUT at col 8 of that line.
    task automatic run_frame(input int nl, input int pat, input bit simul, input int rl);
        int off;
        int v;
        int c;
        int row;
        logic hs;
        logic vs;
        logic vis;
        logic frm;
        logic [5:0] col6;
        off = simul ? 2 : 1;
        for (int l = 0; l < nl; l++) begin
            for (int t = 0; t < LT; t++) begin
                hs  = (t >= HSL);
                vs  = !(l < 2 || (l == 2 && t < (simul ? HSL : 0)));
                v   = l - off;
                c   = t - T0;
                vis = (c >= 0) && (c < HP) && (v >= VB) && (v < VB + VP * VR) && (((v - VB) % VR) == 0);
                row = (v >= VB) ? (v - VB) / VR : 0;
                if (rl >= 0 && (l * LT + t >= rl * LT + T0 + 8)) vis = 1'b0;
                if (pat == 0) col6 = vis ? 6'((row + c) & 63) : 6'((t * 3) & 63);
                else          col6 = 6'((l * 5 + t) & 63);
                frm = (t == HSL) && (v == VB + VP * VR) && (rl < 0);
                do_tick({vs, hs, col6}, frm, vis, 15'(row * HP + c), col6);
                if (l == 2 && t == 0) begin
                    lock_mid   = o_locked;
                    frames_mid = frames_seen;
                end
                if (rl >= 0 && l == rl && t == T0 + 8) begin
                    @(negedge i_clock);
                    #1 i_reset = 1'b1;
                    #1;
                    check("rst_we",     int'(o_fb_we),   0);
                    check("rst_addr",   int'(o_fb_addr), 0);
                    check("rst_data",   int'(o_fb_data), 0);
                    check("rst_locked", int'(o_locked),  0);
                    check("rst_frame",  int'(o_frame),   0);
                    #1 i_reset = 1'b0;
                end
            end
        end
    endtask

    initial begin
        i_reset = 1'b1;
        i_ready = 1'b0;
        i_out   = 8'hC0;
        repeat (2) @(posedge i_clock);
        #1;
        check("reset_we",     int'(o_fb_we),   0);
        check("reset_addr",   int'(o_fb_addr), 0);
        check("reset_data",   int'(o_fb_data), 0);
        check("reset_frame",  int'(o_frame),   0);
        check("reset_locked", int'(o_locked),  0);
        i_reset = 1'b0;
        running = 1'b1;

        // Golden frame
        base = wr_total; d_first = 6'd63; d_last = 6'd63;
        run_frame(NL, 0, 1'b0, -1);
        check("golden_writes", wr_total - base, 96);
        check("golden_frames", frames_seen, 1);
        check("golden_locked", int'(o_locked), 1);
        check("golden_addr0",  int'(d_first), 0);
        check("golden_last",   int'(d_last), 20);

        // Same frame with random stalls
        base = wr_total; d_first = 6'd63; d_last = 6'd63;
        stall = 1'b1;
        run_frame(NL, 0, 1'b0, -1);
        stall = 1'b0;
        check("stall_writes", wr_total - base, 96);
        check("stall_frames", frames_seen, 2);
        check("stall_addr0",  int'(d_first), 0);
        check("stall_last",   int'(d_last), 20);

        // Lines within a repeat group carry different colours
        base = wr_total; d_first = 6'd63; d_last = 6'd63;
        run_frame(NL, 1, 1'b0, -1);
        check("repeat_writes", wr_total - base, 96);
        check("repeat_addr0",  int'(d_first), 41);
        check("repeat_last",   int'(d_last), 28);

        // Truncated frame: next frame's vsync falls after 12 visible lines
        base = wr_total;
        run_frame(VB + 1 + 12, 0, 1'b0, -1);
        check("trunc_writes", wr_total - base, 48);
        base = wr_total;
        run_frame(NL, 0, 1'b0, -1);
        check("trunc_unlock",   int'(lock_mid), 0);
        check("trunc_noframe",  frames_mid, 3);
        check("relock_writes",  wr_total - base, 96);
        check("relock_frames",  frames_seen, 4);
        check("relock_locked",  int'(o_locked), 1);

        // hsync and vsync rising together
        base = wr_total; d_first = 6'd63; d_last = 6'd63;
        run_frame(NL, 0, 1'b1, -1);
        check("simul_writes", wr_total - base, 96);
        check("simul_frames", frames_seen, 5);
        check("simul_addr0",  int'(d_first), 0);
        check("simul_last",   int'(d_last), 20);

        // Reset at column 8 of row 2
        base = wr_total;
        run_frame(NL, 0, 1'b0, VB + 1 + 2 * VR);
        check("rstmid_writes", wr_total - base, 40);
        check("rstmid_frames", frames_seen, 5);
        check("rstmid_locked", int'(o_locked), 0);

        // Capture restarts on the next frame
        base = wr_total;
        run_frame(NL, 0, 1'b0, -1);
        check("restart_writes", wr_total - base, 96);
        check("restart_frames", frames_seen, 6);
        check("restart_locked", int'(o_locked), 1);

        repeat (4) @(posedge i_clock);
        #1;
        check("queue_empty", exp_q.size(), 0);
        running = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
